// File: rtl/seq_mult_pkg.sv
// Shared types for the sequential shift-add multiplier.
// The 2*WIDTH accumulator type depends on the WIDTH parameter, so it is declared inside the top module.
package seq_mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        SIGN = 2'd2
    } state_t;

endpackage

// File: rtl/seq_mult_absneg.sv
// Combinational conditional negate.
// abs_mode=1: take the magnitude of x when en=1. abs_mode=0: negate x whenever en=1.
module seq_mult_absneg #(
    parameter int W = 8
) (
    input  logic [W-1:0] x,
    input  logic         en,
    input  logic         abs_mode,
    output logic [W-1:0] y
);

    logic do_negate;

    always_comb begin
        do_negate = en && (!abs_mode || x[W-1]);
        y         = do_negate ? -x : x;
    end

endmodule

// File: rtl/seq_multiplier_param.sv
// Parametrised shift-add sequential multiplier with start/busy/done handshake and synchronous abort.
// Optional macro SEQ_MULT_EARLY_EXIT_EN ends CALC once the remaining multiplier magnitude is zero.
module seq_multiplier_param
    import seq_mult_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic               abort,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   multiplier,
    input  logic [WIDTH-1:0]   multiplicand,
    output logic [2*WIDTH-1:0] product,
    output logic               busy,
    output logic               done
);

    typedef logic [2*WIDTH-1:0] acc_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   mplr_q, mplr_d;
    acc_t               mcand_q, mcand_d;
    acc_t               acc_q, acc_d;
    logic               neg_q, neg_d;
    acc_t               product_q, product_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [WIDTH-1:0]   mag_a, mag_b;
    acc_t               signed_acc;
    logic [WIDTH-1:0]   mplr_next;
    logic               last_iter;

    seq_mult_absneg #(.W(WIDTH)) u_abs_a (
        .x(multiplier), .en(signed_mode), .abs_mode(1'b1), .y(mag_a)
    );

    seq_mult_absneg #(.W(WIDTH)) u_abs_b (
        .x(multiplicand), .en(signed_mode), .abs_mode(1'b1), .y(mag_b)
    );

    seq_mult_absneg #(.W(2*WIDTH)) u_neg_res (
        .x(acc_q), .en(neg_q), .abs_mode(1'b0), .y(signed_acc)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mplr_d    = mplr_q;
        mcand_d   = mcand_q;
        acc_d     = acc_q;
        neg_d     = neg_q;
        product_d = product_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        mplr_next = mplr_q >> 1;
`ifdef SEQ_MULT_EARLY_EXIT_EN
        last_iter = (cnt_q == CNT_W'(1)) || (mplr_next == '0);
`else
        last_iter = (cnt_q == CNT_W'(1));
`endif

        case (state_q)
            IDLE: begin
                // start has priority over abort here: abort only cancels in-flight work
                if (start) begin
                    mplr_d    = mag_a;
                    mcand_d   = acc_t'(mag_b);
                    neg_d     = signed_mode && (multiplier[WIDTH-1] ^ multiplicand[WIDTH-1]);
                    acc_d     = '0;
                    cnt_d     = CNT_W'(WIDTH);
                    product_d = '0;
                    busy_d    = 1'b1;
                    state_d   = CALC;
                end
            end
            CALC: begin
                if (abort) begin
                    product_d = '0;
                    busy_d    = 1'b0;
                    state_d   = IDLE;
                end else begin
                    if (mplr_q[0]) begin
                        acc_d = acc_q + mcand_q;
                    end
                    mplr_d  = mplr_next;
                    mcand_d = mcand_q << 1;
                    cnt_d   = cnt_q - CNT_W'(1);
                    if (last_iter) begin
                        state_d = SIGN;
                    end
                end
            end
            SIGN: begin
                busy_d  = 1'b0;
                state_d = IDLE;
                if (abort) begin
                    product_d = '0;
                end else begin
                    product_d = signed_acc;
                    done_d    = 1'b1;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            mplr_q    <= '0;
            mcand_q   <= '0;
            acc_q     <= '0;
            neg_q     <= 1'b0;
            product_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mplr_q    <= mplr_d;
            mcand_q   <= mcand_d;
            acc_q     <= acc_d;
            neg_q     <= neg_d;
            product_q <= product_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign product = product_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_seq_multiplier_param.sv
// Self-checking bench for seq_multiplier_param: WIDTH=8 vector table and corner sequences, WIDTH=16 random sweep.
// Expected latency follows SEQ_MULT_EARLY_EXIT_EN when the macro is defined for the build.
module tb_seq_multiplier_param;

    logic        clk;
    logic        reset_n;

    logic        start8, abort8, sm8;
    logic [7:0]  a8, b8;
    logic [15:0] p8;
    logic        busy8, done8;

    logic        start16, abort16, sm16;
    logic [15:0] a16, b16;
    logic [31:0] p16;
    logic        busy16, done16;

    int checks;
    int failures;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        bit          s;
        logic [15:0] p;
    } vec_t;

    vec_t vecs [8];

    seq_multiplier_param #(.WIDTH(8)) dut8 (
        .clk(clk), .reset_n(reset_n), .start(start8), .abort(abort8),
        .signed_mode(sm8), .multiplier(a8), .multiplicand(b8),
        .product(p8), .busy(busy8), .done(done8)
    );

    seq_multiplier_param #(.WIDTH(16)) dut16 (
        .clk(clk), .reset_n(reset_n), .start(start16), .abort(abort16),
        .signed_mode(sm16), .multiplier(a16), .multiplicand(b16),
        .product(p16), .busy(busy16), .done(done16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Plain signed/unsigned arithmetic, reduced to 2*w bits
    function automatic logic [31:0] ref_product(input logic [15:0] a, input logic [15:0] b,
                                                input bit s, input int w);
        longint sa, sb, p, m;
        sa = longint'(a);
        sb = longint'(b);
        if (s && a[w-1]) sa = sa - (longint'(1) << w);
        if (s && b[w-1]) sb = sb - (longint'(1) << w);
        m = longint'(1) << (2 * w);
        p = (sa * sb) % m;
        if (p < 0) p = p + m;
        return p[31:0];
    endfunction

    // Edges after the start edge until done is seen
    function automatic int exp_edges(input logic [15:0] a, input bit s, input int w);
        longint mag;
        int     it;
        mag = longint'(a);
        if (s && a[w-1]) mag = (longint'(1) << w) - mag;
        it = 1;
        for (int i = 0; i < w; i++) if (mag[i]) it = i + 1;
`ifdef SEQ_MULT_EARLY_EXIT_EN
        return it + 1;
`else
        return w + 1;
`endif
    endfunction

    task automatic wait_done8(output int edges, output int busy_cnt);
        edges    = 0;
        busy_cnt = busy8 ? 1 : 0;
        while (!done8 && edges < 200) begin
            tick();
            edges++;
            if (busy8) busy_cnt++;
        end
        if (!done8) check("done8_timeout", 32'd0, 32'd1);
    endtask

    task automatic start_op8(input logic [7:0] a, input logic [7:0] b, input bit s);
        a8 = a; b8 = b; sm8 = s; start8 = 1'b1;
        tick();
        start8 = 1'b0;
    endtask

    initial begin
        int  edges, bcnt, n;
        bit  seen;
        checks   = 0;
        failures = 0;

        vecs[0] = '{8'd200, 8'd150, 1'b0, 16'd30000};
        vecs[1] = '{8'h80,  8'h80,  1'b1, 16'h4000};
        vecs[2] = '{8'hFD,  8'd7,   1'b1, 16'hFFEB};
        vecs[3] = '{8'd0,   8'd255, 1'b0, 16'h0000};
        vecs[4] = '{8'hFF,  8'hFF,  1'b0, 16'hFE01};
        vecs[5] = '{8'h7F,  8'h80,  1'b1, 16'hC080};
        vecs[6] = '{8'hFF,  8'hFF,  1'b1, 16'h0001};
        vecs[7] = '{8'h01,  8'h80,  1'b1, 16'hFF80};

        reset_n = 1'b0;
        start8 = 0; abort8 = 0; sm8 = 0; a8 = 0; b8 = 0;
        start16 = 0; abort16 = 0; sm16 = 0; a16 = 0; b16 = 0;
        tick();
        tick();
        check("reset_product", 32'(p8), 32'd0);
        check("reset_busy", 32'(busy8), 32'd0);
        check("reset_done", 32'(done8), 32'd0);
        reset_n = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) begin
            start_op8(vecs[i].a, vecs[i].b, vecs[i].s);
            wait_done8(edges, bcnt);
            check($sformatf("vec%0d_product", i), 32'(p8), 32'(vecs[i].p));
            check($sformatf("vec%0d_latency", i), 32'(edges), 32'(exp_edges(16'(vecs[i].a), vecs[i].s, 8)));
            check($sformatf("vec%0d_busy_cycles", i), 32'(bcnt), 32'(exp_edges(16'(vecs[i].a), vecs[i].s, 8)));
            check($sformatf("vec%0d_busy_at_done", i), 32'(busy8), 32'd0);
            tick();
            check($sformatf("vec%0d_done_pulse", i), 32'(done8), 32'd0);
            check($sformatf("vec%0d_hold", i), 32'(p8), 32'(vecs[i].p));
        end

        // start re-pulsed while busy is ignored
        start_op8(8'd200, 8'd150, 1'b0);
        tick();
        tick();
        a8 = 8'd3; b8 = 8'd3; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        wait_done8(edges, bcnt);
        check("repulse_product", 32'(p8), 32'd30000);
        check("repulse_latency", 32'(edges + 3), 32'(exp_edges(16'd200, 1'b0, 8)));

        // start in the done cycle is accepted and clears the product
        start_op8(8'd5, 8'd6, 1'b0);
        check("done_cycle_accept_busy", 32'(busy8), 32'd1);
        check("done_cycle_accept_clear", 32'(p8), 32'd0);
        wait_done8(edges, bcnt);
        check("done_cycle_second_product", 32'(p8), 32'd30);
        check("done_cycle_second_latency", 32'(edges), 32'(exp_edges(16'd5, 1'b0, 8)));
        tick();

        // abort on the fourth CALC iteration
        start_op8(8'h55, 8'd3, 1'b0);
        tick(); tick(); tick();
        abort8 = 1'b1;
        tick();
        abort8 = 1'b0;
        check("abort_calc_busy", 32'(busy8), 32'd0);
        check("abort_calc_done", 32'(done8), 32'd0);
        check("abort_calc_product", 32'(p8), 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (done8) seen = 1'b1;
        end
        check("abort_calc_no_done", 32'(seen), 32'd0);
        start_op8(8'd12, 8'd11, 1'b0);
        wait_done8(edges, bcnt);
        check("after_abort_product", 32'(p8), 32'd132);
        tick();

        // abort while in SIGN suppresses the result
        start_op8(8'd9, 8'd9, 1'b0);
        n = exp_edges(16'd9, 1'b0, 8) - 1;
        for (int i = 0; i < n; i++) tick();
        abort8 = 1'b1;
        tick();
        abort8 = 1'b0;
        check("abort_sign_done", 32'(done8), 32'd0);
        check("abort_sign_busy", 32'(busy8), 32'd0);
        check("abort_sign_product", 32'(p8), 32'd0);
        tick();

        // start and abort together in IDLE: start wins
        a8 = 8'd13; b8 = 8'd10; sm8 = 1'b0; start8 = 1'b1; abort8 = 1'b1;
        tick();
        start8 = 1'b0; abort8 = 1'b0;
        check("start_wins_busy", 32'(busy8), 32'd1);
        wait_done8(edges, bcnt);
        check("start_wins_product", 32'(p8), 32'd130);

        // asynchronous reset while a product is held, then mid-CALC
        #3 reset_n = 1'b0;
        #1 check("async_reset_held_product", 32'(p8), 32'd0);
        #2 reset_n = 1'b1;
        tick();
        start_op8(8'd200, 8'd150, 1'b0);
        tick(); tick(); tick();
        #3 reset_n = 1'b0;
        #1 check("async_reset_busy", 32'(busy8), 32'd0);
        check("async_reset_done", 32'(done8), 32'd0);
        #2 reset_n = 1'b1;
        tick();
        start_op8(8'd7, 8'd9, 1'b0);
        wait_done8(edges, bcnt);
        check("after_reset_product", 32'(p8), 32'd63);
        tick();

        // WIDTH=16 random sweep against the arithmetic model
        for (int i = 0; i < 40; i++) begin
            logic [15:0] ra, rb;
            bit          rs;
            ra = 16'($urandom_range(0, 65535));
            rb = 16'($urandom_range(0, 65535));
            rs = 1'($urandom_range(0, 1));
            if (i == 0) begin ra = 16'h8000; rb = 16'h8000; rs = 1'b1; end
            if (i == 1) begin ra = 16'h0001; rb = 16'hFFFF; rs = 1'b1; end
            if (i == 2) begin ra = 16'h0000; rb = 16'h1234; rs = 1'b0; end
            a16 = ra; b16 = rb; sm16 = rs; start16 = 1'b1;
            tick();
            start16 = 1'b0;
            a16 = 16'($urandom_range(0, 65535));
            b16 = 16'($urandom_range(0, 65535));
            sm16 = ~rs;
            edges = 0;
            while (!done16 && edges < 200) begin
                tick();
                edges++;
            end
            check($sformatf("rnd%0d_product a=%0h b=%0h s=%0d", i, ra, rb, rs), p16, ref_product(ra, rb, rs, 16));
            check($sformatf("rnd%0d_latency", i), 32'(edges), 32'(exp_edges(ra, rs, 16)));
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
